// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM encoding, command bytes and device responses.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_START     = 3'd2,
    ST_SEND      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } ps2_state_t;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;

  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK  = 8'hAA;

  // Bits driven on device clock edges after the start bit: 8 data, parity, stop.
  localparam logic [3:0] LAST_BIT_IDX = 4'd9;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Two-flop synchronizer with falling-edge detect for the PS/2 clock and data lines.
module ps2_edge_sync (
  input  logic clk_in,
  input  logic rst_in,
  input  logic key_clk,
  input  logic key_data,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall,
  output logic data_fall
);

  logic [1:0] raw;
  logic [1:0] sync;
  logic [1:0] fall;

  assign raw = {key_data, key_clk};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      logic meta_reg;
      logic sync_reg;
      logic prev_reg;

      // Reset to the idle-high level so leaving reset never looks like an edge.
      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
          prev_reg <= 1'b1;
        end else begin
          meta_reg <= raw[gi];
          sync_reg <= meta_reg;
          prev_reg <= sync_reg;
        end
      end

      assign sync[gi] = sync_reg;
      assign fall[gi] = prev_reg & ~sync_reg;
    end
  endgenerate

  assign clk_sync  = sync[0];
  assign data_sync = sync[1];
  assign clk_fall  = fall[0];
  assign data_fall = fall[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, bit shifting on device clock edges,
// ACK sampling and a frame timeout; all outputs registered.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int SETUP_CYCLES   = 100,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       key_clk,
  input  logic       key_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int PHASE_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
  localparam int TO_W      = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PHASE_W-1:0] INHIBIT_LAST = PHASE_W'(INHIBIT_CYCLES - 1);
  localparam logic [PHASE_W-1:0] SETUP_LAST   = PHASE_W'(SETUP_CYCLES - 1);
  localparam logic [TO_W-1:0]    TO_LAST      = TO_W'(TIMEOUT_CYCLES - 1);

  logic clk_sync;
  logic data_sync;
  logic clk_fall;
  logic data_fall_unused;

  ps2_edge_sync u_sync (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .key_clk   (key_clk),
    .key_data  (key_data),
    .clk_sync  (clk_sync),
    .data_sync (data_sync),
    .clk_fall  (clk_fall),
    .data_fall (data_fall_unused)
  );

  ps2_state_t          state_reg, state_next;
  logic [PHASE_W-1:0]  phase_cnt_reg;
  logic [TO_W-1:0]     to_cnt_reg;
  logic [3:0]          bit_cnt_reg;
  logic [9:0]          frame_reg;
  logic                ack_bad_reg;

  logic clk_oe_reg,   clk_oe_next;
  logic data_oe_reg,  data_oe_next;
  logic tx_ready_reg, tx_ready_next;
  logic busy_reg,     busy_next;
  logic done_reg,     done_next;
  logic ack_err_reg,  ack_err_next;
  logic timeout_reg,  timeout_next;

  logic accept;
  logic in_frame;
  logic to_hit;
  logic lines_idle;

  assign accept     = tx_valid & tx_ready_reg;
  assign in_frame   = (state_reg == ST_SEND) || (state_reg == ST_ACK) ||
                      (state_reg == ST_WAIT_IDLE);
  assign to_hit     = in_frame && (to_cnt_reg == TO_LAST);
  assign lines_idle = clk_sync & data_sync;

  always_ff @(posedge clk_in) begin
    if (rst_in) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:      if (accept) state_next = ST_INHIBIT;
      ST_INHIBIT:   if (phase_cnt_reg == INHIBIT_LAST) state_next = ST_START;
      ST_START:     if (phase_cnt_reg == SETUP_LAST) state_next = ST_SEND;
      ST_SEND: begin
        if (to_hit)                                          state_next = ST_IDLE;
        else if (clk_fall && bit_cnt_reg == LAST_BIT_IDX)    state_next = ST_ACK;
      end
      ST_ACK: begin
        if (to_hit)        state_next = ST_IDLE;
        else if (clk_fall) state_next = ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE:  if (to_hit || lines_idle) state_next = ST_IDLE;
      default:       state_next = ST_IDLE;
    endcase
  end

  // Line drives follow the state being entered so every output is a plain register.
  always_comb begin
    clk_oe_next   = (state_next == ST_INHIBIT) || (state_next == ST_START);
    data_oe_next  = 1'b0;
    if (state_next == ST_START) begin
      data_oe_next = 1'b1;
    end else if (state_next == ST_SEND) begin
      if (state_reg != ST_SEND) data_oe_next = 1'b1;
      else if (clk_fall)        data_oe_next = ~frame_reg[bit_cnt_reg];
      else                      data_oe_next = data_oe_reg;
    end
    tx_ready_next = (state_next == ST_IDLE);
    busy_next     = (state_next != ST_IDLE);
    done_next     = (state_reg == ST_WAIT_IDLE) && !to_hit && lines_idle;
    ack_err_next  = done_next & ack_bad_reg;
    timeout_next  = to_hit;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      clk_oe_reg   <= 1'b0;
      data_oe_reg  <= 1'b0;
      tx_ready_reg <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      ack_err_reg  <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      clk_oe_reg   <= clk_oe_next;
      data_oe_reg  <= data_oe_next;
      tx_ready_reg <= tx_ready_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      ack_err_reg  <= ack_err_next;
      timeout_reg  <= timeout_next;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      phase_cnt_reg <= '0;
      to_cnt_reg    <= '0;
      bit_cnt_reg   <= '0;
      frame_reg     <= '0;
      ack_bad_reg   <= 1'b0;
    end else begin
      if (accept) begin
        frame_reg   <= {1'b1, odd_parity(tx_data), tx_data};
        bit_cnt_reg <= '0;
      end else if (state_reg == ST_SEND && clk_fall) begin
        bit_cnt_reg <= bit_cnt_reg + 4'd1;
      end

      if ((state_next == state_reg) &&
          (state_reg == ST_INHIBIT || state_reg == ST_START))
        phase_cnt_reg <= phase_cnt_reg + PHASE_W'(1);
      else
        phase_cnt_reg <= '0;

      // Zero until SEND is entered, then counts every cycle of the frame.
      if (in_frame && state_next != ST_IDLE)
        to_cnt_reg <= to_cnt_reg + TO_W'(1);
      else
        to_cnt_reg <= '0;

      if (state_reg == ST_ACK && clk_fall)
        ack_bad_reg <= data_sync;
    end
  end

  assign ps2_clk_oe  = clk_oe_reg;
  assign ps2_data_oe = data_oe_reg;
  assign tx_ready    = tx_ready_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign ack_err     = ack_err_reg;
  assign timeout     = timeout_reg;

endmodule
